// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: control inputs from decode, memory word in, IF/ID and status out.
// The fetch unit is the master (it drives IAddress and the IF/ID outputs).
interface pc_fetch_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic                start;
  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_offset;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_addr;
  logic [15:0]         instr_in;
  logic [PC_WIDTH-1:0] IAddress;
  logic [15:0]         id_instr;
  logic [PC_WIDTH-1:0] id_pc;
  logic                id_valid;
  logic                halted;
  logic                fault;

  modport master (
    input  start, stall, branch_taken, branch_offset, jump, jump_addr, instr_in,
    output IAddress, id_instr, id_pc, id_valid, halted, fault
  );

  modport slave (
    output start, stall, branch_taken, branch_offset, jump, jump_addr, instr_in,
    input  IAddress, id_instr, id_pc, id_valid, halted, fault
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, presents it to instruction memory and latches the
// returned word into the IF/ID register. Handles stall, branch/jump redirect
// with flush, halt-on-opcode and an out-of-range PC fault.
module pc_fetch_unit #(
  parameter int unsigned         PC_WIDTH  = 16,
  parameter int unsigned         MEM_DEPTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [3:0]          HALT_OP   = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  pc_fetch_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted, StFault} state_e;

  // One extra bit so MEM_DEPTH == 2**PC_WIDTH still compares correctly.
  localparam logic [PC_WIDTH:0] MemDepthW = (PC_WIDTH + 1)'(MEM_DEPTH);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         id_instr_q, id_instr_d;
  logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
  logic                id_valid_q, id_valid_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;

  logic                redirect;
  logic                pc_oor;
  logic                halt_hit;
  logic [PC_WIDTH-1:0] redirect_pc;

  // Decode-side conditions; redirects only count against a real instruction.
  always_comb begin
    redirect    = id_valid_q && (bus.jump || bus.branch_taken);
    pc_oor      = {1'b0, pc_q} >= MemDepthW;
    halt_hit    = id_valid_q && (id_instr_q[3:0] == HALT_OP);
    redirect_pc = bus.jump ? bus.jump_addr
                           : id_pc_q + PC_WIDTH'(1) + bus.branch_offset;
  end

  // Next-state: fault > halt > redirect > stall > sequential while running.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    unique case (state_q)
      StIdle: begin
        id_valid_d = 1'b0;
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        if (pc_oor && !redirect) begin
          state_d    = StFault;
          id_valid_d = 1'b0;
          halted_d   = 1'b1;
          fault_d    = 1'b1;
        end else if (halt_hit) begin
          // The word fetched behind the halt is dropped.
          state_d    = StHalted;
          id_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (redirect) begin
          pc_d       = redirect_pc;
          id_valid_d = 1'b0;
          id_instr_d = '0;
        end else if (!bus.stall) begin
          id_instr_d = bus.instr_in;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + PC_WIDTH'(1);
        end
      end
      StHalted, StFault: begin
        // Terminal until reset.
      end
    endcase
  end

  // All state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.IAddress = pc_q;
  assign bus.id_instr = id_instr_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_valid = id_valid_q;
  assign bus.halted   = halted_q;
  assign bus.fault    = fault_q;

endmodule
